// File: rtl/ptp_wb_pkg.sv
// Shared definitions for the external Wishbone bus arbiter: default bus
// geometry, watchdog limit and the arbiter state encoding.
package ptp_wb_pkg;

  localparam int WB_AW      = 32;
  localparam int WB_DW      = 32;
  localparam int WB_TIMEOUT = 1024;

  // Forced-termination event counter saturates here instead of wrapping.
  localparam logic [7:0] TMO_COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts granted cycles without a slave ack, flags expiry at
// TIMEOUT-1, and keeps a saturating count of forced terminations.
module wb_watchdog
  import ptp_wb_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic       evt_i,
  output logic       expire_o,
  output logic [7:0] evt_count_o
);

  localparam int             CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    evt_q, evt_d;

  // Next-state for the cycle counter and the saturating event counter.
  always_comb begin
    cnt_d = cnt_q;
    evt_d = evt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (evt_i && (evt_q != TMO_COUNT_MAX)) begin
      evt_d = evt_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      evt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign expire_o    = (cnt_q == LIMIT);
  assign evt_count_o = evt_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter. Round-robin grant held for
// a whole cyc..ack transfer; a watchdog force-acks transfers the slave never
// answers so the CPU cannot hang on the bus.
module wb_master_arbiter
  import ptp_wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic            clock_main,
  input  logic            rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic            tmo_pulse_o,
  output logic [7:0]      tmo_count_o
);

  arb_state_e state_q;
  logic       last_grant_q;   // 0: m0 was granted last, 1: m1

  logic req0, req1, granted, gnt_cyc, wd_expire, tmo_fire;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign gnt_cyc = (state_q == GNT0) ? m0_cyc_i : m1_cyc_i;

  // A real ack in the expiry cycle wins; an aborting master gets no forced ack.
  assign tmo_fire    = granted & wd_expire & ~s_ack_i & gnt_cyc & ~rst;
  assign tmo_pulse_o = tmo_fire;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk         (clock_main),
    .rst         (rst),
    .clear_i     (state_q == IDLE),
    .run_i       (granted & ~s_ack_i),
    .evt_i       (tmo_fire),
    .expire_o    (wd_expire),
    .evt_count_o (tmo_count_o)
  );

  // Bus steering: granted master passes through, everything else held at 0.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    if (!rst) begin
      case (state_q)
        GNT0: begin
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          s_sel_o  = m0_sel_i;
          s_we_o   = m0_we_i;
          s_stb_o  = req0 & ~tmo_fire;
          s_cyc_o  = req0 & ~tmo_fire;
          m0_ack_o = (s_ack_i & m0_cyc_i) | tmo_fire;
          m0_dat_o = tmo_fire ? '0 : s_dat_i;
        end
        GNT1: begin
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          s_sel_o  = m1_sel_i;
          s_we_o   = m1_we_i;
          s_stb_o  = req1 & ~tmo_fire;
          s_cyc_o  = req1 & ~tmo_fire;
          m1_ack_o = (s_ack_i & m1_cyc_i) | tmo_fire;
          m1_dat_o = tmo_fire ? '0 : s_dat_i;
        end
        default: ;
      endcase
    end
  end

  // Grant FSM: round-robin on ties, release on ack, abort or watchdog expiry.
  always_ff @(posedge clock_main) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_grant_q)) begin
            state_q      <= GNT0;
            last_grant_q <= 1'b0;
          end else if (req1) begin
            state_q      <= GNT1;
            last_grant_q <= 1'b1;
          end
        end
        GNT0: if (!m0_cyc_i || s_ack_i || tmo_fire) state_q <= IDLE;
        GNT1: if (!m1_cyc_i || s_ack_i || tmo_fire) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for the two-master Wishbone arbiter (TIMEOUT = 16).
module tb_wb_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam logic [31:0] A0 = 32'h0300_0010;
  localparam logic [31:0] A1 = 32'h0300_0100;

  logic          clock_main = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o;
  logic          m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o;
  logic          s_we_o, s_stb_o, s_cyc_o, s_ack_i, tmo_pulse_o;
  logic [7:0]    tmo_count_o;

  int checks   = 0;
  int failures = 0;

  wb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clock_main (clock_main), .rst (rst),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
    .m0_we_i (m0_we_i), .m0_stb_i (m0_stb_i), .m0_cyc_i (m0_cyc_i),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
    .m1_we_i (m1_we_i), .m1_stb_i (m1_stb_i), .m1_cyc_i (m1_cyc_i),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
    .s_we_o (s_we_o), .s_stb_o (s_stb_o), .s_cyc_o (s_cyc_o),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
    .tmo_pulse_o (tmo_pulse_o), .tmo_count_o (tmo_count_o)
  );

  always #5 clock_main = ~clock_main;

  task automatic step();
    @(posedge clock_main);
    #1;
  endtask

  task automatic clear_masters();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
  endtask

  task automatic req_m0(input logic [31:0] adr);
    m0_adr_i = adr; m0_sel_i = 4'hF; m0_we_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
  endtask

  task automatic req_m1(input logic [31:0] adr);
    m1_adr_i = adr; m1_sel_i = 4'hF; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
  endtask

  task automatic do_reset();
    rst = 1; clear_masters(); s_ack_i = 0; s_dat_i = '0;
    step(); step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clear_masters(); s_ack_i = 0; s_dat_i = '0;
    req_m0(A0);
    step(); step();
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_s_cyc got=%b exp=0", s_cyc_o); end
    checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL rst_m0_ack got=%b exp=0", m0_ack_o); end
    clear_masters();
    rst = 0;
    #1;
    checks++; if (tmo_count_o !== 8'd0) begin failures++; $display("FAIL rst_tmo_count got=%0d exp=0", tmo_count_o); end
    checks++; if (s_adr_o !== 32'h0) begin failures++; $display("FAIL rst_s_adr got=%h exp=0", s_adr_o); end
  endtask

  task automatic test_single_read();
    req_m0(A0);
    #1;
    checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL rd_latency_stb got=%b exp=0", s_stb_o); end
    step();
    checks++; if (s_stb_o !== 1'b1 || s_adr_o !== A0) begin failures++; $display("FAIL rd_grant stb=%b adr=%h exp stb=1 adr=%h", s_stb_o, s_adr_o, A0); end
    checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%b exp=0", m0_ack_o); end
    step(); step();
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL rd_ack ack=%b dat=%h exp ack=1 dat=12345678", m0_ack_o, m0_dat_o); end
    checks++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin failures++; $display("FAIL rd_m1_quiet ack=%b dat=%h exp 0/0", m1_ack_o, m1_dat_o); end
    step();
    s_ack_i = 0; clear_masters();
    #1;
    checks++; if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL rd_idle_after cyc=%b ack=%b exp 0/0", s_cyc_o, m0_ack_o); end
  endtask

  task automatic test_tie_alternation();
    do_reset();
    req_m0(A0); req_m1(A1);
    step();
    checks++; if (s_adr_o !== A0) begin failures++; $display("FAIL tie1_first got=%h exp=%h", s_adr_o, A0); end
    s_ack_i = 1; s_dat_i = 32'h0000_0011;
    #1;
    checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin failures++; $display("FAIL tie1_ack m0=%b m1=%b m1dat=%h exp 1/0/0", m0_ack_o, m1_ack_o, m1_dat_o); end
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL tie1_dead_cycle cyc=%b m1ack=%b exp 0/0", s_cyc_o, m1_ack_o); end
    step();
    checks++; if (s_adr_o !== A1 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL tie1_second adr=%h cyc=%b exp %h/1", s_adr_o, s_cyc_o, A1); end
    s_ack_i = 1;
    #1;
    checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL tie1_m1_ack m1=%b m0=%b exp 1/0", m1_ack_o, m0_ack_o); end
    step();
    s_ack_i = 0; req_m0(A0);
    step();
    checks++; if (s_adr_o !== A0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL tie2_alternate adr=%h cyc=%b exp %h/1", s_adr_o, s_cyc_o, A0); end
    s_ack_i = 1;
    step();
    s_ack_i = 0; clear_masters();
    step();
  endtask

  task automatic test_m1_write();
    m1_adr_i = A1; m1_dat_i = 32'hCAFE_F00D; m1_sel_i = 4'b0011; m1_we_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    checks++; if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011) begin failures++; $display("FAIL wr_ctrl we=%b sel=%b exp 1/0011", s_we_o, s_sel_o); end
    checks++; if (s_dat_o !== 32'hCAFE_F00D || s_adr_o !== A1) begin failures++; $display("FAIL wr_data dat=%h adr=%h exp cafef00d/%h", s_dat_o, s_adr_o, A1); end
    s_ack_i = 1;
    #1;
    checks++; if (m1_ack_o !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", m1_ack_o); end
    step();
    s_ack_i = 0; clear_masters();
    step();
  endtask

  task automatic test_timeout();
    s_dat_i = 32'hDEAD_BEEF;
    req_m0(A0);
    step();
    repeat (TMO - 2) step();
    checks++; if (m0_ack_o !== 1'b0 || tmo_pulse_o !== 1'b0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL tmo_before ack=%b pulse=%b cyc=%b exp 0/0/1", m0_ack_o, tmo_pulse_o, s_cyc_o); end
    step();
    checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h0) begin failures++; $display("FAIL tmo_forced_ack ack=%b dat=%h exp 1/0", m0_ack_o, m0_dat_o); end
    checks++; if (tmo_pulse_o !== 1'b1 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL tmo_pulse pulse=%b cyc=%b stb=%b exp 1/0/0", tmo_pulse_o, s_cyc_o, s_stb_o); end
    step();
    clear_masters();
    #1;
    checks++; if (tmo_count_o !== 8'd1 || tmo_pulse_o !== 1'b0) begin failures++; $display("FAIL tmo_count1 cnt=%0d pulse=%b exp 1/0", tmo_count_o, tmo_pulse_o); end
    // real ack landing in the expiry cycle
    req_m0(A0);
    step();
    repeat (TMO - 1) step();
    s_ack_i = 1;
    #1;
    checks++; if (tmo_pulse_o !== 1'b0 || m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL tmo_ack_wins pulse=%b ack=%b dat=%h exp 0/1/deadbeef", tmo_pulse_o, m0_ack_o, m0_dat_o); end
    step();
    s_ack_i = 0; clear_masters();
    #1;
    checks++; if (tmo_count_o !== 8'd1) begin failures++; $display("FAIL tmo_count_unchanged got=%0d exp=1", tmo_count_o); end
    // hold the request so timeouts repeat every TMO+1 cycles
    req_m0(A0);
    repeat (300 * (TMO + 1)) step();
    clear_masters();
    step(); step();
    checks++; if (tmo_count_o !== 8'd255) begin failures++; $display("FAIL tmo_saturate got=%0d exp=255", tmo_count_o); end
  endtask

  task automatic test_reset_mid_transfer();
    s_dat_i = '0;
    req_m0(A0);
    step(); step();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL rstmid_drop cyc=%b ack=%b exp 0/0", s_cyc_o, m0_ack_o); end
    checks++; if (tmo_count_o !== 8'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", tmo_count_o); end
    clear_masters();
    step();
    req_m0(A0); req_m1(A1);
    step();
    checks++; if (s_adr_o !== A0) begin failures++; $display("FAIL rstmid_tie got=%h exp=%h", s_adr_o, A0); end
    s_ack_i = 1;
    step();
    s_ack_i = 0; clear_masters();
    step();
  endtask

  task automatic test_abort();
    req_m1(A1);
    step();
    checks++; if (s_adr_o !== A1 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL abort_grant adr=%h cyc=%b exp %h/1", s_adr_o, s_cyc_o, A1); end
    req_m0(A0); m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    checks++; if (m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL abort_cycle ack=%b cyc=%b exp 0/0", m1_ack_o, s_cyc_o); end
    step();
    checks++; if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL abort_idle cyc=%b ack=%b exp 0/0", s_cyc_o, m1_ack_o); end
    step();
    checks++; if (s_adr_o !== A0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL abort_m0_grant adr=%h cyc=%b exp %h/1", s_adr_o, s_cyc_o, A0); end
    s_ack_i = 1;
    step();
    s_ack_i = 0; clear_masters();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_alternation();
    test_m1_write();
    test_timeout();
    test_reset_mid_transfer();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
